// File: rtl/trap_csr_unit_pkg.sv
// ============================================================================
//  Module      : trap_csr_unit_pkg
//  Description : CSR addresses, trap cause codes, mstatus bit positions and
//                sequencer state encoding shared by the trap/CSR unit.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package trap_csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [1:0] CSR_OP_RW = 2'b01;
    localparam logic [1:0] CSR_OP_RS = 2'b10;
    localparam logic [1:0] CSR_OP_RC = 2'b11;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE, CSR_MHARTID: csr_implemented = 1'b1;
            default:                                        csr_implemented = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_csr_unit_if.sv
// ============================================================================
//  Module      : trap_csr_unit_if
//  Description : E-stage CSR/trap request bundle and pipeline control returns.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface trap_csr_unit_if;
    logic        valid_E;
    logic        stall_E;
    logic        Is_ECALL_E;
    logic        Is_MRET_E;
    logic        Illegal_Instr_E;
    logic        CSRWrite_E;
    logic [2:0]  csr_funct3_E;
    logic [11:0] csr_addr_E;
    logic        csr_rs1_zero_E;
    logic [31:0] csr_src_E;
    logic [31:0] PC_E;
    logic [31:0] Instr_E;
    logic [31:0] csr_rdata_E;
    logic        flush_DE;
    logic        trap_busy;
    logic        pc_redirect;
    logic [31:0] pc_target;

    modport master (
        output valid_E, stall_E, Is_ECALL_E, Is_MRET_E, Illegal_Instr_E, CSRWrite_E,
               csr_funct3_E, csr_addr_E, csr_rs1_zero_E, csr_src_E, PC_E, Instr_E,
        input  csr_rdata_E, flush_DE, trap_busy, pc_redirect, pc_target
    );

    modport slave (
        input  valid_E, stall_E, Is_ECALL_E, Is_MRET_E, Illegal_Instr_E, CSRWrite_E,
               csr_funct3_E, csr_addr_E, csr_rs1_zero_E, csr_src_E, PC_E, Instr_E,
        output csr_rdata_E, flush_DE, trap_busy, pc_redirect, pc_target
    );
endinterface

`default_nettype wire

// File: rtl/trap_csr_unit_csr_file.sv
// ============================================================================
//  Module      : trap_csr_unit_csr_file
//  Description : Machine-mode CSR storage, read mux, RW/RS/RC merge, mcycle.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module trap_csr_unit_csr_file
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        addr_ok,
    input  logic        csr_we,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_src,
    input  logic        trap_en,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_en,
    output logic [31:0] mtvec_base,
    output logic [31:0] mepc_aligned
);

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mcycle;
    logic [31:0] w_wdata;

    assign addr_ok      = csr_implemented(addr);
    assign mtvec_base   = r_mtvec & ~32'h3;
    assign mepc_aligned = r_mepc & ~32'h3;

    always_comb begin
        rdata = 32'd0;
        case (addr)
            CSR_MSTATUS: begin
                rdata                 = 32'h0000_1800;
                rdata[MSTATUS_MIE]    = r_mie;
                rdata[MSTATUS_MPIE]   = r_mpie;
            end
            CSR_MTVEC:    rdata = mtvec_base;
            CSR_MSCRATCH: rdata = r_mscratch;
            CSR_MEPC:     rdata = mepc_aligned;
            CSR_MCAUSE:   rdata = r_mcause;
            CSR_MTVAL:    rdata = r_mtval;
            CSR_MCYCLE:   rdata = r_mcycle;
            CSR_MHARTID:  rdata = HART_ID;
            default:      rdata = 32'd0;
        endcase
    end

    // Merge uses the architecturally visible old value (masked fields included).
    always_comb begin
        w_wdata = rdata;
        case (csr_op)
            CSR_OP_RW: w_wdata = csr_src;
            CSR_OP_RS: w_wdata = rdata | csr_src;
            CSR_OP_RC: w_wdata = rdata & ~csr_src;
            default:   w_wdata = rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
            r_mcycle   <= 32'd0;
        end else begin
            r_mcycle <= r_mcycle + 32'd1;
            if (trap_en) begin
                r_mepc   <= trap_pc;
                r_mcause <= trap_cause;
                r_mtval  <= trap_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (mret_en) begin
                r_mie    <= r_mpie;
                r_mpie   <= 1'b1;
            end else if (csr_we) begin
                // A software write to mcycle overrides the increment above.
                case (addr)
                    CSR_MSTATUS: begin
                        r_mie  <= w_wdata[MSTATUS_MIE];
                        r_mpie <= w_wdata[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:    r_mtvec    <= w_wdata;
                    CSR_MSCRATCH: r_mscratch <= w_wdata;
                    CSR_MEPC:     r_mepc     <= w_wdata;
                    CSR_MCAUSE:   r_mcause   <= w_wdata;
                    CSR_MTVAL:    r_mtval    <= w_wdata;
                    CSR_MCYCLE:   r_mcycle   <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/trap_csr_unit.sv
// ============================================================================
//  Module      : trap_csr_unit
//  Description : E-stage trap/MRET sequencer with redirect FSM around the CSR file.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module trap_csr_unit
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic           clk,
    input  logic           reset,
    trap_csr_unit_if.slave bus
);

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [31:0] r_pc_target;
    logic        w_act;
    logic [1:0]  w_op;
    logic        w_write_attempt;
    logic        w_addr_ok;
    logic        w_csr_illegal;
    logic        w_illegal;
    logic        w_trap;
    logic        w_mret;
    logic        w_csr_we;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_mepc_aligned;
    logic        w_unused;

    // funct3[2] only selects register vs. immediate source, already folded into csr_src_E.
    assign w_unused = bus.csr_funct3_E[2];

    assign w_act           = bus.valid_E & ~bus.stall_E & (r_state == ST_IDLE);
    assign w_op            = bus.csr_funct3_E[1:0];
    assign w_write_attempt = (w_op == CSR_OP_RW) |
                             (((w_op == CSR_OP_RS) | (w_op == CSR_OP_RC)) & ~bus.csr_rs1_zero_E);
    assign w_csr_illegal   = bus.CSRWrite_E &
                             (~w_addr_ok | (w_write_attempt & (bus.csr_addr_E[11:10] == 2'b11)));
    assign w_illegal       = bus.Illegal_Instr_E | w_csr_illegal;
    assign w_trap          = w_act & (w_illegal | bus.Is_ECALL_E);
    assign w_mret          = w_act & ~w_illegal & ~bus.Is_ECALL_E & bus.Is_MRET_E;
    assign w_csr_we        = w_act & ~w_illegal & ~bus.Is_ECALL_E & ~bus.Is_MRET_E &
                             bus.CSRWrite_E & w_write_attempt;

    trap_csr_unit_csr_file #(
        .MTVEC_RESET (MTVEC_RESET),
        .HART_ID     (HART_ID)
    ) u_csr_file (
        .clk          (clk),
        .reset        (reset),
        .addr         (bus.csr_addr_E),
        .rdata        (bus.csr_rdata_E),
        .addr_ok      (w_addr_ok),
        .csr_we       (w_csr_we),
        .csr_op       (w_op),
        .csr_src      (bus.csr_src_E),
        .trap_en      (w_trap),
        .trap_cause   (w_illegal ? CAUSE_ILLEGAL : CAUSE_ECALL),
        .trap_pc      (bus.PC_E),
        .trap_tval    (w_illegal ? bus.Instr_E : 32'd0),
        .mret_en      (w_mret),
        .mtvec_base   (w_mtvec_base),
        .mepc_aligned (w_mepc_aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_trap | w_mret) w_state_next = ST_REDIRECT;
            ST_REDIRECT: w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.flush_DE    = 1'b0;
        bus.trap_busy   = 1'b0;
        bus.pc_redirect = 1'b0;
        case (r_state)
            ST_IDLE:     bus.flush_DE = w_trap | w_mret;
            ST_REDIRECT: begin
                bus.flush_DE    = 1'b1;
                bus.trap_busy   = 1'b1;
                bus.pc_redirect = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_target <= 32'd0;
        end else if (w_trap) begin
            r_pc_target <= w_mtvec_base;
        end else if (w_mret) begin
            r_pc_target <= w_mepc_aligned;
        end
    end

    assign bus.pc_target = r_pc_target;

endmodule

`default_nettype wire
